// File: rtl/dinteg.sv
// Sign-magnitude running integrator Y(n) = Y(n-1) + D(n), saturating at +/-(2^WIDTH-1).
// Latency: 1 cycle from in_valid/load to out_valid with updated Y/Y_sign/sat.
// Backpressure: none; every valid sample is accepted, load/clr pre-empt a concurrent sample.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   clr               clear accumulator to +0 and drop sat_sticky
//   load              preload accumulator with {ld_sign, ld_val}
//   in_valid, D,      difference sample (magnitude + sign, sign=1 negative)
//   D_sign
//   out_valid, Y,     registered reconstructed sample
//   Y_sign
//   sat               one-cycle pulse when the last update clamped
//   sat_sticky        latched saturation flag, cleared only by rst/clr
module dinteg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             ld_sign,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] D,
    input  logic             D_sign,
    output logic             out_valid,
    output logic [WIDTH-1:0] Y,
    output logic             Y_sign,
    output logic             sat,
    output logic             sat_sticky
);

    logic             d_neg;     // input sign with -0 folded to +0
    logic [WIDTH:0]   sum;       // one extra bit to catch magnitude overflow
    logic [WIDTH-1:0] nxt_mag;
    logic             raw_sign;
    logic             nxt_sign;
    logic             nxt_sat;

    always_comb begin
        d_neg    = D_sign & (D != '0);
        sum      = {1'b0, Y} + {1'b0, D};
        nxt_mag  = '0;
        raw_sign = 1'b0;
        nxt_sat  = 1'b0;

        if (Y_sign == d_neg) begin
            // Same sign: magnitudes add, clamp symmetric on either polarity.
            raw_sign = d_neg;
            if (sum[WIDTH]) begin
                nxt_mag = '1;
                nxt_sat = 1'b1;
            end else begin
                nxt_mag = sum[WIDTH-1:0];
            end
        end else if (Y >= D) begin
            // Opposite signs: larger magnitude keeps its sign; cannot overflow.
            nxt_mag  = Y - D;
            raw_sign = Y_sign;
        end else begin
            nxt_mag  = D - Y;
            raw_sign = d_neg;
        end

        // Never emit -0.
        nxt_sign = raw_sign & (nxt_mag != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Y          <= '0;
            Y_sign     <= 1'b0;
            out_valid  <= 1'b0;
            sat        <= 1'b0;
            sat_sticky <= 1'b0;
        end else if (clr) begin
            Y          <= '0;
            Y_sign     <= 1'b0;
            out_valid  <= 1'b0;
            sat        <= 1'b0;
            sat_sticky <= 1'b0;
        end else if (load) begin
            // Sticky flag deliberately survives a preload.
            Y         <= ld_val;
            Y_sign    <= ld_sign & (ld_val != '0);
            out_valid <= 1'b1;
            sat       <= 1'b0;
        end else if (in_valid) begin
            Y          <= nxt_mag;
            Y_sign     <= nxt_sign;
            out_valid  <= 1'b1;
            sat        <= nxt_sat;
            sat_sticky <= sat_sticky | nxt_sat;
        end else begin
            out_valid <= 1'b0;
            sat       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dinteg.sv
// Bench for dinteg: directed vector table, hand-written multi-cycle sequences,
// random stimulus against a signed-integer reference model, and a
// difference-stream reconstruction run.
module tb_dinteg;

    localparam int W   = 16;
    localparam int MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst, clr, load, ld_sign, in_valid, D_sign;
    logic [W-1:0] ld_val, D;
    logic         out_valid, Y_sign, sat, sat_sticky;
    logic [W-1:0] Y;

    always #5 clk = ~clk;

    dinteg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .load       (load),
        .ld_val     (ld_val),
        .ld_sign    (ld_sign),
        .in_valid   (in_valid),
        .D          (D),
        .D_sign     (D_sign),
        .out_valid  (out_valid),
        .Y          (Y),
        .Y_sign     (Y_sign),
        .sat        (sat),
        .sat_sticky (sat_sticky)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit clr;
        bit load;
        int ld_val;
        bit ld_sign;
        bit iv;
        int d;
        bit ds;
        int ey;
        bit es;
        bit eov;
        bit esat;
        bit est;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit c, input bit l, input int lv, input bit ls,
                       input bit iv, input int d, input bit ds,
                       input int ey, input bit es, input bit eov, input bit esat, input bit est);
        vec_t v;
        v.clr = c; v.load = l; v.ld_val = lv; v.ld_sign = ls;
        v.iv = iv; v.d = d; v.ds = ds;
        v.ey = ey; v.es = es; v.eov = eov; v.esat = esat; v.est = est;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ey, input bit es,
                             input bit eov, input bit esat, input bit est);
        check({tag, ".Y"},          32'(Y),     ey);
        check({tag, ".Y_sign"},     32'(Y_sign),  32'(es));
        check({tag, ".out_valid"},  32'(out_valid), 32'(eov));
        check({tag, ".sat"},        32'(sat),   32'(esat));
        check({tag, ".sat_sticky"}, 32'(sat_sticky), 32'(est));
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input bit ls,
                         input bit iv, input int d, input bit ds);
        clr = c; load = l; ld_val = W'(lv); ld_sign = ls;
        in_valid = iv; D = W'(d); D_sign = ds;
    endtask

    // Advance one edge and leave the sampling point 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: accumulator held as a plain signed integer.
    int m_acc;
    bit m_ov, m_sat, m_st;

    task automatic model_step(input bit r, input bit c, input bit l, input int lv,
                              input bit ls, input bit iv, input int d, input bit ds);
        int t;
        if (r || c) begin
            m_acc = 0; m_ov = 0; m_sat = 0; m_st = 0;
        end else if (l) begin
            m_acc = ls ? -lv : lv; m_ov = 1; m_sat = 0;
        end else if (iv) begin
            t = m_acc + (ds ? -d : d);
            m_sat = 0;
            if (t > MAX) begin t = MAX; m_sat = 1; end
            if (t < -MAX) begin t = -MAX; m_sat = 1; end
            m_acc = t; m_ov = 1; m_st = m_st | m_sat;
        end else begin
            m_ov = 0; m_sat = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        //  clr load ldv   lds iv d      ds   Y      s ov sat st
        add(0, 0, 0,     0, 1, 5,     0,   5,     0, 1, 0, 0);
        add(0, 0, 0,     0, 1, 3,     0,   8,     0, 1, 0, 0);
        add(0, 0, 0,     0, 1, 10,    1,   2,     1, 1, 0, 0);
        add(0, 0, 0,     0, 1, 2,     0,   0,     0, 1, 0, 0);
        add(0, 0, 0,     0, 1, 0,     1,   0,     0, 1, 0, 0);
        add(0, 0, 0,     0, 0, 0,     0,   0,     0, 0, 0, 0);
        add(0, 1, 65530, 0, 0, 0,     0,   65530, 0, 1, 0, 0);
        add(0, 0, 0,     0, 1, 10,    0,   65535, 0, 1, 1, 1);
        add(0, 0, 0,     0, 1, 5,     1,   65530, 0, 1, 0, 1);
        add(0, 0, 0,     0, 0, 0,     0,   65530, 0, 0, 0, 1);
        add(1, 0, 0,     0, 0, 0,     0,   0,     0, 0, 0, 0);
        add(0, 1, 65530, 1, 0, 0,     0,   65530, 1, 1, 0, 0);
        add(0, 0, 0,     0, 1, 10,    1,   65535, 1, 1, 1, 1);
        add(0, 1, 7,     0, 1, 100,   0,   7,     0, 1, 0, 1);
        add(1, 1, 9,     0, 1, 100,   0,   0,     0, 0, 0, 0);
        add(0, 1, 0,     1, 0, 0,     0,   0,     0, 1, 0, 0);
        add(0, 0, 0,     0, 1, 3,     1,   3,     1, 1, 0, 0);
        add(0, 0, 0,     0, 1, 3,     0,   0,     0, 1, 0, 0);
        add(0, 0, 0,     0, 1, 65535, 1,   65535, 1, 1, 0, 0);
        add(0, 0, 0,     0, 1, 1,     1,   65535, 1, 1, 1, 1);
        add(0, 0, 0,     0, 1, 65535, 0,   0,     0, 1, 0, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].load, tbl[i].ld_val, tbl[i].ld_sign,
                  tbl[i].iv, tbl[i].d, tbl[i].ds);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].ey, tbl[i].es,
                      tbl[i].eov, tbl[i].esat, tbl[i].est);
        end

        // Reset mid-stream: accumulator lost, restarts from +0.
        drive(0, 1, 100, 0, 0, 0, 0);
        tick();
        check_all("midrst.load", 100, 0, 1, 0, 1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 1, 50, 0);
        tick();
        check_all("midrst.rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 4, 1);
        tick();
        check_all("midrst.next", 4, 1, 1, 0, 0);

        // sat pulse lasts one cycle, sticky persists over idle cycles.
        drive(0, 1, 65535, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 1, 0);
        tick();
        check_all("satpulse.hit", 65535, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_all("satpulse.idle1", 65535, 0, 0, 0, 1);
        tick();
        check_all("satpulse.idle2", 65535, 0, 0, 0, 1);

        // Random mixed traffic against the integer model.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        model_step(1, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            bit r, c, l, ls, iv, ds;
            int lv, d, sel;
            sel = int'($urandom_range(99));
            r   = (sel == 0);
            c   = (sel >= 1 && sel <= 2);
            l   = (sel >= 3 && sel <= 7);
            iv  = (sel >= 20) || ($urandom_range(1) == 1);
            lv  = ($urandom_range(3) == 0) ? MAX - int'($urandom_range(3)) : int'($urandom_range(MAX));
            ls  = 1'($urandom_range(1));
            d   = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(MAX / 4));
            ds  = 1'($urandom_range(1));
            rst = r;
            drive(c, l, lv, ls, iv, d, ds);
            tick();
            model_step(r, c, l, lv, ls, iv, d, ds);
            check_all($sformatf("rand%0d", k), (m_acc < 0) ? -m_acc : m_acc,
                      m_acc < 0, m_ov, m_sat, m_st);
        end
        rst = 1'b0;

        // Reconstruction: feed A(n)-A(n-1) and expect A(n) back, no saturation.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        begin
            int prev;
            int a, diff;
            prev = 0;
            for (int k = 0; k < 10000; k++) begin
                a    = int'($urandom_range(65534)) - 32767;
                diff = a - prev;
                drive(0, 0, 0, 0, 1, (diff < 0) ? -diff : diff, diff < 0);
                tick();
                check($sformatf("recon%0d", k),
                      {13'd0, sat, out_valid, Y_sign, Y},
                      {13'd0, 1'b0, 1'b1, (a < 0) ? 1'b1 : 1'b0, W'((a < 0) ? -a : a)});
                prev = a;
            end
        end
        check("recon.sticky", 32'(sat_sticky), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
